// File: rtl/mdr_mem_port.sv
// MAR/MDR register pair with a wait-state SRAM access controller.
// Registers freeze while an access is in flight; finished reads may auto-load the MDR.
module mdr_mem_port #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter bit AUTO_LOAD   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              Mem_Req,
  input  logic              Mem_WE,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic [ADDR_W-1:0] MAR_out,
  output logic [DATA_W-1:0] MDR_out,
  output logic              Mem_CS,
  output logic              Mem_RD,
  output logic              Mem_WR,
  output logic              Busy,
  output logic              Mem_Ready
);

  localparam int CW   = $clog2(WAIT_CYCLES + 1);
  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            op, op_n;
  logic            start, rd_done, ld_ok;
  logic [MAXW-1:0] bus_ext;

  // Zero-extend or truncate the bus to address width.
  always_comb begin
    bus_ext = '0;
    bus_ext[DATA_W-1:0] = Bus_In;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op    <= op_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    start   = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Mem_Req) begin
          start   = 1'b1;
          state_n = ACCESS;
          cnt_n   = CW'(WAIT_CYCLES - 1);
          op_n    = Mem_WE;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = DONE;
          rd_done = ~op;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ld_ok = (state != ACCESS);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      MAR_out <= '0;
      MDR_out <= '0;
    end else begin
      if (ld_ok && LD_MAR)
        MAR_out <= bus_ext[ADDR_W-1:0];
      // Auto-load outranks LD_MDR, though both cannot coincide since loads are blocked in ACCESS.
      if (AUTO_LOAD && rd_done)
        MDR_out <= Mem_Rdata;
      else if (ld_ok && LD_MDR)
        MDR_out <= MIO_EN ? Mem_Rdata : Bus_In;
    end
  end

  // Outputs decode only registered state.
  assign Mem_CS    = (state == ACCESS);
  assign Busy      = (state == ACCESS);
  assign Mem_RD    = (state == ACCESS) & ~op;
  assign Mem_WR    = (state == ACCESS) & op;
  assign Mem_Ready = (state == DONE);

  logic unused_start;
  assign unused_start = start;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed vector bench for mdr_mem_port: main instance plus WAIT_CYCLES=1/15 AUTO_LOAD=0 variants.
module tb_mdr_mem_port;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Bus_In, Mem_Rdata;
  logic        LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE;

  logic [15:0] mar0, mdr0, mar1, mdr1, mar2, mdr2;
  logic        cs0, rd0, wr0, bsy0, rdy0;
  logic        cs1, rd1, wr1, bsy1, rdy1;
  logic        cs2, rd2, wr2, bsy2, rdy2;

  always #5 Clk = ~Clk;

  mdr_mem_port #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2), .AUTO_LOAD(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Rdata(Mem_Rdata),
    .MAR_out(mar0), .MDR_out(mdr0), .Mem_CS(cs0), .Mem_RD(rd0), .Mem_WR(wr0),
    .Busy(bsy0), .Mem_Ready(rdy0));

  mdr_mem_port #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1), .AUTO_LOAD(1'b0)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Rdata(Mem_Rdata),
    .MAR_out(mar1), .MDR_out(mdr1), .Mem_CS(cs1), .Mem_RD(rd1), .Mem_WR(wr1),
    .Busy(bsy1), .Mem_Ready(rdy1));

  mdr_mem_port #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(15), .AUTO_LOAD(1'b0)) dut_w15 (
    .Clk(Clk), .Reset(Reset), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Rdata(Mem_Rdata),
    .MAR_out(mar2), .MDR_out(mdr2), .Mem_CS(cs2), .Mem_RD(rd2), .Mem_WR(wr2),
    .Busy(bsy2), .Mem_Ready(rdy2));

  typedef struct {
    logic        rst, ldmar, ldmdr, mio, req, we;
    logic [15:0] bus, rdata;
    logic [15:0] emar, emdr;
    logic        ecs, erd, ewr, ebusy, erdy;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic add(input logic rst, ldmar, ldmdr, mio, input logic [15:0] bus, rdata,
                     input logic req, we, input logic [15:0] emar, emdr,
                     input logic ecs, erd, ewr, erdy);
    vec_t v;
    v.rst = rst; v.ldmar = ldmar; v.ldmdr = ldmdr; v.mio = mio; v.bus = bus;
    v.rdata = rdata; v.req = req; v.we = we; v.emar = emar; v.emdr = emdr;
    v.ecs = ecs; v.erd = erd; v.ewr = ewr; v.ebusy = ecs; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, ldmar, ldmdr, mio, input logic [15:0] bus, rdata,
                       input logic req, we);
    Reset = rst; LD_MAR = ldmar; LD_MDR = ldmdr; MIO_EN = mio;
    Bus_In = bus; Mem_Rdata = rdata; Mem_Req = req; Mem_WE = we;
  endtask

  initial begin
    int k_rdy0, k_rdy1, k_rdy2, s0, s1, s2, r0, r1, r2;
    drive(1, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    //   rst ldA ldD mio bus       rdata     req we  | mar       mdr       cs rd wr rdy
    add(1, 1, 1, 1, 16'hFFFF, 16'hA5A5, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h1234, 16'h5555, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h3001, 16'h0000, 0, 0, 16'h3001, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'hBEEF, 16'h0000, 0, 0, 16'h3001, 16'hBEEF, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h1234, 0, 0, 16'h3001, 16'h1234, 0, 0, 0, 0);
    // read, 2 wait states
    add(0, 0, 0, 0, 16'h0000, 16'hCAFE, 1, 0, 16'h3001, 16'h1234, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hCAFE, 0, 0, 16'h3001, 16'h1234, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hCAFE, 0, 0, 16'h3001, 16'hCAFE, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h3001, 16'hCAFE, 0, 0, 0, 0);
    // write
    add(0, 1, 0, 0, 16'h4000, 16'h0000, 0, 0, 16'h4000, 16'hCAFE, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'h00FF, 16'h0000, 0, 0, 16'h4000, 16'h00FF, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h1111, 1, 1, 16'h4000, 16'h00FF, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h2222, 0, 0, 16'h4000, 16'h00FF, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h3333, 0, 0, 16'h4000, 16'h00FF, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4000, 16'h00FF, 0, 0, 0, 0);
    // loads and requests ignored during ACCESS
    add(0, 0, 0, 0, 16'h0000, 16'h5A5A, 1, 0, 16'h4000, 16'h00FF, 1, 1, 0, 0);
    add(0, 1, 1, 0, 16'hFFFF, 16'h5A5A, 1, 1, 16'h4000, 16'h00FF, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h5A5A, 0, 0, 16'h4000, 16'h5A5A, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4000, 16'h5A5A, 0, 0, 0, 0);
    // Mem_Req held: back-to-back writes, period 3
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h4000, 16'h5A5A, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h4000, 16'h5A5A, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h4000, 16'h5A5A, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h4000, 16'h5A5A, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4000, 16'h5A5A, 1, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4000, 16'h5A5A, 0, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h4000, 16'h5A5A, 0, 0, 0, 0);
    // same-edge MAR load with Mem_Req
    add(0, 1, 0, 0, 16'h0123, 16'h7777, 1, 0, 16'h0123, 16'h5A5A, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h7777, 0, 0, 16'h0123, 16'h5A5A, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h7777, 0, 0, 16'h0123, 16'h7777, 0, 0, 0, 1);
    // reset mid-access aborts with no Mem_Ready and no MDR update
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hBBBB, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 16'hBBBB, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hBBBB, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].rst, vecs[i].ldmar, vecs[i].ldmdr, vecs[i].mio,
            vecs[i].bus, vecs[i].rdata, vecs[i].req, vecs[i].we);
      @(posedge Clk); #1;
      chk("MAR_out",   i, 32'(mar0), 32'(vecs[i].emar));
      chk("MDR_out",   i, 32'(mdr0), 32'(vecs[i].emdr));
      chk("Mem_CS",    i, 32'(cs0),  32'(vecs[i].ecs));
      chk("Mem_RD",    i, 32'(rd0),  32'(vecs[i].erd));
      chk("Mem_WR",    i, 32'(wr0),  32'(vecs[i].ewr));
      chk("Busy",      i, 32'(bsy0), 32'(vecs[i].ebusy));
      chk("Mem_Ready", i, 32'(rdy0), 32'(vecs[i].erdy));
    end

    // Parameter sweep: preload MDR, then a single-cycle read request on all instances.
    @(negedge Clk); drive(1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    @(negedge Clk); drive(0, 0, 1, 0, 16'h1357, 16'h0, 0, 0);
    @(negedge Clk); drive(0, 0, 0, 0, 16'h0, 16'h9999, 1, 0);
    k_rdy0 = 0; k_rdy1 = 0; k_rdy2 = 0;
    s0 = 0; s1 = 0; s2 = 0; r0 = 0; r1 = 0; r2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      s0 += int'(rd0 & cs0); s1 += int'(rd1 & cs1); s2 += int'(rd2 & cs2);
      r0 += int'(rdy0); r1 += int'(rdy1); r2 += int'(rdy2);
      if (rdy0 && k_rdy0 == 0) k_rdy0 = k;
      if (rdy1 && k_rdy1 == 0) k_rdy1 = k;
      if (rdy2 && k_rdy2 == 0) k_rdy2 = k;
      @(negedge Clk); Mem_Req = 1'b0;
    end
    chk("strobe_len_w2",  0, 32'(s0), 32'd2);
    chk("strobe_len_w1",  0, 32'(s1), 32'd1);
    chk("strobe_len_w15", 0, 32'(s2), 32'd15);
    chk("ready_cycle_w2",  0, 32'(k_rdy0), 32'd3);
    chk("ready_cycle_w1",  0, 32'(k_rdy1), 32'd2);
    chk("ready_cycle_w15", 0, 32'(k_rdy2), 32'd16);
    chk("ready_count_w2",  0, 32'(r0), 32'd1);
    chk("ready_count_w1",  0, 32'(r1), 32'd1);
    chk("ready_count_w15", 0, 32'(r2), 32'd1);
    chk("mdr_autoload_w2",  0, 32'(mdr0), 32'h9999);
    chk("mdr_noload_w1",    0, 32'(mdr1), 32'h1357);
    chk("mdr_noload_w15",   0, 32'(mdr2), 32'h1357);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
